div_thread_sched: RTL
=====================

Name: div_thread_sched

Overview:
Shares the single sequential divider among NTHREADS hardware threads. Each thread raises a divide request with operands. A round-robin arbiter grants one request at a time, launches the divider with a one-cycle enable, waits for completion, and returns the quotient tagged with the owning thread id. The block sits between the per-thread issue slots and the divider instance, and adds flush handling and a hang watchdog.

Parameters:
NTHREADS, 4, number of requesting threads (2..8)
TID_W, 2, thread id width, equal to clog2(NTHREADS)
TIMEOUT, 64, maximum cycles spent in BUSY before an abort

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous reset, active-low (asserted at 0)
req_valid  in  NTHREADS  per-thread request; held until accepted
req_a  in  NTHREADS*32  dividend, thread t at bits [32t+31:32t]
req_b  in  NTHREADS*32  divisor, same packing
req_uns  in  NTHREADS  unsigned divide (divwu) flag
req_oe  in  NTHREADS  OE bit of the instruction
req_ack  out  NTHREADS  one-hot, one-cycle acceptance pulse
flush  in  NTHREADS  cancel any pending or in-flight divide of thread t
div_en  out  1  divider start pulse
div_uns  out  1  unsigned mode to the divider
div_a  out  32  dividend to the divider
div_b  out  32  divisor to the divider
div_ready  in  1  divider idle and able to start
div_complete  in  1  divider result valid, one-cycle pulse
div_quot  in  32  divider quotient
div_ov  in  1  divider overflow / divide-by-zero
res_valid  out  1  result pulse
res_thread  out  TID_W  owning thread of the result
res_quot  out  32  quotient
res_ov  out  1  overflow
res_oe  out  1  latched OE of the granted request
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (reset=0, async): state=IDLE; rr_ptr=0; watchdog=0. All outputs are 0: req_ack, div_en, div_uns, div_a, div_b, res_*, timeout_err.
- FSM states: IDLE, START, BUSY, DONE.
- IDLE: let eligible = req_valid & ~flush. If eligible!=0 and div_ready=1:
  - Pick the first set bit searching from rr_ptr upward, wrapping modulo NTHREADS.
  - Pulse req_ack for that thread in the same cycle.
  - Latch the thread's operands, uns and oe, and the thread id as owner.
  - Set rr_ptr = owner+1, wrapping to 0 after NTHREADS-1.
  - Go to START.
  - If div_ready=0, stay in IDLE with no ack.
- START: div_en=1 for exactly one cycle. div_a, div_b and div_uns drive the latched values and stay stable until the FSM leaves BUSY. Clear the watchdog. Go to BUSY.
- BUSY: the watchdog increments each cycle.
  - If div_complete=1: register quot and ov, set cancelled |= flush[owner], go to DONE.
  - Else if watchdog==TIMEOUT-1: pulse timeout_err, go to IDLE, no result.
- DONE: res_valid=1 for one cycle with res_thread=owner and the registered res_quot, res_ov and res_oe, unless the owner was flushed at any point from START to DONE inclusive. A flushed result gives res_valid=0. Then go to IDLE. An arbitration decision is never made in the DONE cycle.
- Latency: acceptance in cycle N; div_en in N+1; divider completion in cycle C; res_valid in C+1. The minimum re-issue interval is one IDLE cycle after DONE.
- flush only suppresses the result; the divider always runs to completion. A flush on a non-owner thread masks that thread's eligibility in the same cycle only.
- When res_valid=0, res_thread, res_quot, res_ov and res_oe are driven to 0.
- A div_complete outside BUSY is ignored.
- A requester must keep req_valid and operands stable until req_ack. Dropping req_valid before ack is legal and simply withdraws the request.

Test Plan:
- Single request: thread 2 requests a=100, b=7, uns=1, oe=0; divider completes 5 cycles after div_en with quot=14 -> req_ack=4'b0100 in cycle N, div_en in N+1, res_valid with res_thread=2, res_quot=14, res_ov=0 in cycle C+1.
- Round-robin: all 4 threads request continuously from reset -> grant order is 0,1,2,3,0; each thread gets exactly one ack per 4 results.
- Flush in flight: thread 1 granted, flush[1] pulsed during BUSY -> div_complete accepted, res_valid stays 0, next request granted normally.
- Divide by zero: a=5, b=0, divider reports ov=1 -> res_ov=1, res_oe equals the latched oe (test both 0 and 1).
- Watchdog: with TIMEOUT=64 and div_complete withheld -> timeout_err pulses exactly 64 cycles after entering BUSY, FSM returns to IDLE, a later request is served.
- Reset mid-operation: drive reset=0 during BUSY -> all outputs 0 immediately; after release, no stale res_valid, and rr_ptr is 0 so thread 0 wins the first simultaneous request.

Source files
------------

// File: rtl/div_thread_sched.sv
// Round-robin sharing of one sequential divider among NTHREADS threads, with flush and hang watchdog.
// Ack same cycle as grant, div_en next cycle, result one cycle after div_complete; requests wait while busy or div_ready=0.
module div_thread_sched #(
   parameter int NTHREADS = 4,
   parameter int TID_W    = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NTHREADS-1:0]    req_valid,
   input  logic [NTHREADS*32-1:0] req_a,
   input  logic [NTHREADS*32-1:0] req_b,
   input  logic [NTHREADS-1:0]    req_uns,
   input  logic [NTHREADS-1:0]    req_oe,
   output logic [NTHREADS-1:0]    req_ack,
   input  logic [NTHREADS-1:0]    flush,
   output logic                   div_en,
   output logic                   div_uns,
   output logic [31:0]            div_a,
   output logic [31:0]            div_b,
   input  logic                   div_ready,
   input  logic                   div_complete,
   input  logic [31:0]            div_quot,
   input  logic                   div_ov,
   output logic                   res_valid,
   output logic [TID_W-1:0]       res_thread,
   output logic [31:0]            res_quot,
   output logic                   res_ov,
   output logic                   res_oe,
   output logic                   timeout_err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_BUSY  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]          state_q, state_d;
   logic [TID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [TID_W-1:0]    owner_q;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [31:0]         a_q, b_q, quot_q;
   logic                uns_q, oe_q, ov_q;
   logic                cancel_q;
   logic                timeout_q;

   logic [NTHREADS-1:0] eligible;
   logic [TID_W-1:0]    pick, cand;
   logic                found;
   logic                grant;
   logic                wd_expire;
   logic                owner_flush;

   // A flush on a waiting thread hides it from this cycle's arbitration only.
   assign eligible    = req_valid & ~flush;
   assign owner_flush = flush[owner_q];
   assign wd_expire   = (wd_q == WD_W'(TIMEOUT - 1));

   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NTHREADS; i++) begin
         cand = TID_W'((int'(rr_ptr_q) + i) % NTHREADS);
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign grant   = reset && (state_q == ST_IDLE) && found && div_ready;
   assign req_ack = grant ? (NTHREADS'(1) << pick) : '0;

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      wd_d     = wd_q;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d  = ST_START;
               rr_ptr_d = (pick == TID_W'(NTHREADS - 1)) ? '0 : pick + 1'b1;
            end
         end
         ST_START: begin
            wd_d    = '0;
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            wd_d = wd_q + 1'b1;
            if (div_complete) begin
               state_d = ST_DONE;
            end else if (wd_expire) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         rr_ptr_q  <= '0;
         wd_q      <= '0;
         owner_q   <= '0;
         a_q       <= '0;
         b_q       <= '0;
         uns_q     <= 1'b0;
         oe_q      <= 1'b0;
         quot_q    <= '0;
         ov_q      <= 1'b0;
         cancel_q  <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         wd_q      <= wd_d;
         timeout_q <= (state_q == ST_BUSY) && !div_complete && wd_expire;
         if (grant) begin
            owner_q  <= pick;
            a_q      <= req_a[32*int'(pick) +: 32];
            b_q      <= req_b[32*int'(pick) +: 32];
            uns_q    <= req_uns[pick];
            oe_q     <= req_oe[pick];
            cancel_q <= 1'b0;
         end else if ((state_q == ST_START) || (state_q == ST_BUSY)) begin
            // Sticky: any owner flush between launch and result kills the result.
            cancel_q <= cancel_q | owner_flush;
         end
         if ((state_q == ST_BUSY) && div_complete) begin
            quot_q <= div_quot;
            ov_q   <= div_ov;
         end
      end
   end

   assign div_en      = (state_q == ST_START);
   assign div_a       = a_q;
   assign div_b       = b_q;
   assign div_uns     = uns_q;

   assign res_valid   = (state_q == ST_DONE) && !cancel_q && !owner_flush;
   assign res_thread  = res_valid ? owner_q : '0;
   assign res_quot    = res_valid ? quot_q  : '0;
   assign res_ov      = res_valid && ov_q;
   assign res_oe      = res_valid && oe_q;
   assign timeout_err = timeout_q;

endmodule
